// File: rtl/demux1to2_32_buf.sv
// rtl/demux1to2_32_buf.sv - 1-to-2 demux feeding two registered 2-entry output queues.
// Optional per-output pop counters are enabled by DEMUX_XFER_CNT_EN.
module demux1to2_32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o1,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

  fifo_state_e      st0_q, st0_d, st1_q, st1_d;
  logic [WIDTH-1:0] head0_q, head0_d, tail0_q, tail0_d;
  logic [WIDTH-1:0] head1_q, head1_d, tail1_q, tail1_d;
  logic             push0, push1, pop0, pop1;

  // Readiness looks only at the targeted queue; a full queue never accepts,
  // even when it is being popped in the same cycle.
  always_comb begin
    in_ready = sel ? (st1_q != ST_TWO) : (st0_q != ST_TWO);
    push0    = in_valid && in_ready && !sel;
    push1    = in_valid && in_ready && sel;
    o0_valid = (st0_q != ST_EMPTY);
    o1_valid = (st1_q != ST_EMPTY);
    pop0     = o0_valid && o0_ready;
    pop1     = o1_valid && o1_ready;
    o0       = head0_q;
    o1       = head1_q;
  end

  always_comb begin
    st0_d   = st0_q;
    head0_d = head0_q;
    tail0_d = tail0_q;
    case (st0_q)
      ST_EMPTY: begin
        if (push0) begin
          st0_d   = ST_ONE;
          head0_d = a;
        end
      end
      ST_ONE: begin
        if (push0 && pop0) begin
          head0_d = a;
        end else if (push0) begin
          st0_d   = ST_TWO;
          tail0_d = a;
        end else if (pop0) begin
          st0_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop0) begin
          st0_d   = ST_ONE;
          head0_d = tail0_q;
        end
      end
      default: st0_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    st1_d   = st1_q;
    head1_d = head1_q;
    tail1_d = tail1_q;
    case (st1_q)
      ST_EMPTY: begin
        if (push1) begin
          st1_d   = ST_ONE;
          head1_d = a;
        end
      end
      ST_ONE: begin
        if (push1 && pop1) begin
          head1_d = a;
        end else if (push1) begin
          st1_d   = ST_TWO;
          tail1_d = a;
        end else if (pop1) begin
          st1_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop1) begin
          st1_d   = ST_ONE;
          head1_d = tail1_q;
        end
      end
      default: st1_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q   <= ST_EMPTY;
      st1_q   <= ST_EMPTY;
      head0_q <= '0;
      tail0_q <= '0;
      head1_q <= '0;
      tail1_q <= '0;
    end else begin
      st0_q   <= st0_d;
      st1_q   <= st1_d;
      head0_q <= head0_d;
      tail0_q <= tail0_d;
      head1_q <= head1_d;
      tail1_q <= tail1_d;
    end
  end

`ifdef DEMUX_XFER_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = pop0 ? cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt0_q;
    cnt1_d = pop1 ? cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux1to2_32_buf.sv
// tb/tb_demux1to2_32_buf.sv - table and scoreboard bench for demux1to2_32_buf.
module tb_demux1to2_32_buf;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] o0;
  logic        o0_valid;
  logic        o0_ready;
  logic [31:0] o1;
  logic        o1_valid;
  logic        o1_ready;
  logic [3:0]  cnt0;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;
  int c0 = 0;
  int c1 = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  typedef struct packed {
    logic [31:0] a;
    logic        sel;
    logic        vld;
    logic        r0;
    logic        r1;
    logic        rdy;
  } vec_t;

  vec_t tbl[20];

  demux1to2_32_buf #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .o0(o0), .o0_valid(o0_valid), .o0_ready(o0_ready),
    .o1(o1), .o1_valid(o1_valid), .o1_ready(o1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int c);
`ifdef DEMUX_XFER_CNT_EN
    return 32'(c % 16);
`else
    return 32'(c * 0);
`endif
  endfunction

  // One cycle: drive after negedge, check against the model, then advance the model.
  task automatic step(input logic [31:0] ta, input logic ts, input logic tv,
                      input logic tr0, input logic tr1);
    logic exp_rdy, acc;
    @(negedge clk);
    a = ta; sel = ts; in_valid = tv; o0_ready = tr0; o1_ready = tr1;
    #1;
    exp_rdy = ts ? (q1.size() < 2) : (q0.size() < 2);
    chk("in_ready", in_ready, exp_rdy);
    chk("o0_valid", o0_valid, q0.size() != 0);
    chk("o1_valid", o1_valid, q1.size() != 0);
    if (q0.size() != 0) chk("o0_data", o0, q0[0]);
    if (q1.size() != 0) chk("o1_data", o1, q1[0]);
    chk("cnt0", cnt0, exp_cnt(c0));
    chk("cnt1", cnt1, exp_cnt(c1));
    acc = tv && exp_rdy;
    if (tr0 && q0.size() != 0) begin void'(q0.pop_front()); c0++; end
    if (tr1 && q1.size() != 0) begin void'(q1.pop_front()); c1++; end
    if (acc) begin
      if (ts) q1.push_back(ta);
      else    q0.push_back(ta);
    end
  endtask

  initial begin
    tbl[0]  = '{32'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{32'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{32'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{32'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{32'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; a = '0; sel = 1'b0; in_valid = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0;
    #3;
    chk("rst_o0_valid", o0_valid, 1'b0);
    chk("rst_o1_valid", o1_valid, 1'b0);
    chk("rst_o0", o0, 32'h0);
    chk("rst_o1", o1, 32'h0);
    chk("rst_cnt0", cnt0, 32'h0);
    chk("rst_cnt1", cnt1, 32'h0);
    chk("rst_in_ready_s0", in_ready, 1'b1);
    sel = 1'b1;
    #1;
    chk("rst_in_ready_s1", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].a, tbl[i].sel, tbl[i].vld, tbl[i].r0, tbl[i].r1);
      chk($sformatf("tbl_rdy_%0d", i), in_ready, tbl[i].rdy);
    end

    // Fill both queues, then reset between edges.
    step(32'hA0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(32'hA1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(32'hB0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'hB1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_o0_valid", o0_valid, 1'b0);
    chk("mid_rst_o1_valid", o1_valid, 1'b0);
    chk("mid_rst_o0", o0, 32'h0);
    chk("mid_rst_cnt0", cnt0, 32'h0);
    chk("mid_rst_cnt1", cnt1, 32'h0);
    q0.delete(); q1.delete(); c0 = 0; c1 = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Seventeen output-1 transfers wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) step(32'h100 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef DEMUX_XFER_CNT_EN
    chk("cnt1_after_17", cnt1, 32'h1);
`else
    chk("cnt1_after_17", cnt1, 32'h0);
`endif

    for (int i = 0; i < 300; i++) begin
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to2_32_buf.md
DEMUX1TO2_32_BUF -- requirements
Module: demux1to2_32_buf

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of the input and both output ports.
REQ-002 Parameter CNT_W, default 16, sets the width of each per-output transfer counter.
REQ-003 Port clk input 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n input 1: reset, asynchronous assert and active-low.
REQ-005 Port a input WIDTH: input data word.
REQ-006 Port sel input 1: route select; 0 routes to output 0, 1 routes to output 1, sampled with a.
REQ-007 Port in_valid input 1: a/sel hold a valid word.
REQ-008 Port in_ready output 1: the block accepts the word this cycle.
REQ-009 Port o0 output WIDTH: head word of output-0 queue.
REQ-010 Port o0_valid output 1: o0 holds a valid word.
REQ-011 Port o0_ready input 1: downstream 0 takes o0 this cycle.
REQ-012 Port o1 output WIDTH: head word of output-1 queue.
REQ-013 Port o1_valid output 1: o1 holds a valid word.
REQ-014 Port o1_ready input 1: downstream 1 takes o1 this cycle.
REQ-015 Port cnt0 output CNT_W: count of words popped from output 0.
REQ-016 Port cnt1 output CNT_W: count of words popped from output 1.

Function
REQ-017 An input transfer occurs when in_valid and in_ready are both 1 on a rising edge; an output-k transfer occurs when ok_valid and ok_ready are both 1.
REQ-018 Each output has an independent 2-entry FIFO with states EMPTY, ONE, TWO; push only: EMPTY->ONE, ONE->TWO; pop only: TWO->ONE, ONE->EMPTY; push and pop together: the state is unchanged.
REQ-019 in_ready is combinational: it is 1 when the FIFO selected by sel is not in state TWO, independent of in_valid and of the same-cycle ok_ready (no full-pop bypass).
REQ-020 A word accepted in cycle N is visible on ok with ok_valid=1 no earlier than cycle N+1; there is no combinational path from a to ok.
REQ-021 ok_valid is 1 exactly when FIFO k is not EMPTY; ok and ok_valid are driven from registers.
REQ-022 Each output delivers its words in acceptance order; there is no ordering relation between outputs.
REQ-023 Backpressure on one output never blocks a word whose sel targets the other, non-full output.
REQ-024 A push to EMPTY concurrent with no pop makes that word the head; a push and pop together in state ONE makes the pushed word the head next cycle.
REQ-025 The ok data value while ok_valid=0 holds its last value and is don't-care to consumers.
REQ-026 cntk increments by 1 on every output-k transfer and wraps from 2^CNT_W-1 to 0.
REQ-027 Values of ok_ready while ok_valid=0, and of a/sel while in_valid=0, have no effect.

Reset
REQ-028 While rst_n=0, both FIFOs are EMPTY; o0_valid=o1_valid=0; o0=o1=0; cnt0=cnt1=0; in_ready then reflects only the empty FIFOs (1).
REQ-029 Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge.
REQ-030 The first transfer after reset deassertion is accepted on the first rising edge with rst_n=1.

Configuration
REQ-031 Macro DEMUX_XFER_CNT_EN defined: cnt0/cnt1 counters are implemented per REQ-026.
REQ-032 Macro DEMUX_XFER_CNT_EN undefined: no counter registers exist; cnt0 and cnt1 are tied to constant 0; all other behaviour is identical.

Verification
REQ-033 Reset, then a=32'h0000_00AA, sel=0, in_valid=1 for one cycle, o0_ready=1 -> o0=32'h0000_00AA with o0_valid=1 exactly one cycle later; o1_valid stays 0; cnt0=1.
REQ-034 o0_ready=0; push 32'h11, 32'h22, 32'h33 to sel=0 -> first two accepted, in_ready=0 on the third; release o0_ready -> o0 yields 32'h11 then 32'h22, then 32'h33 once accepted.
REQ-035 Output 0 full and o0_ready=0; push 32'h44 with sel=1 -> accepted immediately, o1=32'h44 next cycle.
REQ-036 FIFO 0 in ONE with head 32'h55; push 32'h66 with o0_ready=1 in the same cycle -> state stays ONE, o0=32'h66 next cycle.
REQ-037 Fill both FIFOs, assert rst_n=0 between clock edges -> o0_valid=o1_valid=0 and counters 0 without waiting for a clock edge; after release, no stale word appears.
REQ-038 With DEMUX_XFER_CNT_EN defined, CNT_W=4, perform 17 output-1 transfers -> cnt1=1; with the macro undefined -> cnt1=0 throughout.
